wb_stage: RTL and testbench
===========================

Name: wb_stage

Overview:
- Writeback stage of the 5-stage ARM pipeline; it sits directly downstream of the memory stage.
- It selects the load data or the ALU result, writes the 16-entry architectural register file, and serves the two decode read ports with same-cycle bypass.
- It registers the committed result for forwarding to execute.
- It raises a one-cycle PC redirect when r15 is written.
- It keeps a retired-instruction counter.

Parameters:
DATA_W, 32, datapath and register width
ADDR_W, 4, register index width (16 registers; index 15 is the PC)
CNT_W, 32, retired-instruction counter width

Ports:
clk_i  input  1  clock; all state updates on the rising edge
reset_i  input  1  synchronous reset, active-low (0 = reset)
ALU_data_i  input  DATA_W  ALU result from the memory stage
mem_data_i  input  DATA_W  load data from the memory stage, aligned with ALU_data_i
wb_addr_i  input  ADDR_W  destination register
valid_i  input  1  slot holds a real instruction
do_write_i  input  1  instruction writes a register
load_i  input  1  select mem_data_i instead of ALU_data_i
flush_i  input  1  squash the current slot
rd_addr_a_i  input  ADDR_W  decode read port A index
rd_addr_b_i  input  ADDR_W  decode read port B index
pc_plus8_i  input  DATA_W  value returned for r15 reads (PC+8)
rd_data_a_o  output  DATA_W  read port A data (combinational)
rd_data_b_o  output  DATA_W  read port B data (combinational)
wb_valid_o  output  1  registered commit valid, for forwarding to execute
wb_addr_o  output  ADDR_W  registered commit destination
wb_data_o  output  DATA_W  registered commit data
redirect_o  output  1  one-cycle PC redirect pulse
redirect_pc_o  output  DATA_W  redirect target
retired_o  output  CNT_W  retired-instruction count

Behaviour:
- Definitions:
  - wdata = load_i ? mem_data_i : ALU_data_i.
  - commit = valid_i & do_write_i & ~flush_i & ~redirect_o.
  - retire = valid_i & ~flush_i & ~redirect_o.
- Shadow cycle: while redirect_o=1, the slot is treated as squashed. It writes nothing, does not count, and raises no new redirect.
- Register file:
  - regs[0..14], DATA_W each; all entries cleared to 0 on reset.
  - On commit with wb_addr_i != 15: regs[wb_addr_i] <= wdata at the clock edge.
  - Writing r15 never touches regs.
- Reads (combinational), evaluated per port:
  - addr == 15 -> pc_plus8_i.
  - Otherwise, if commit and wb_addr_i == addr -> wdata (same-cycle bypass).
  - Otherwise -> regs[addr].
  - Both ports may hit the bypass simultaneously.
- Forwarding register:
  - Each cycle: wb_valid_o <= commit; wb_addr_o <= wb_addr_i; wb_data_o <= wdata.
  - When commit=0, wb_addr_o and wb_data_o still load, but consumers must ignore them.
  - Latency: 1 cycle.
- Redirect:
  - On commit with wb_addr_i == 15: the next cycle drives redirect_o=1 and redirect_pc_o = {wdata[DATA_W-1:2], 2'b00}.
  - Applies to both ALU and load writes of r15.
  - redirect_o is high for exactly one cycle.
  - redirect_pc_o holds its last value when redirect_o=0.
  - Back-to-back r15 commits are impossible because of the shadow cycle.
- Counter:
  - retired_o increments by 1 on each retire, including non-writing instructions (stores, compares).
  - It saturates at all-ones; no wrap.
- Flush: flush_i=1 squashes the slot fully (no write, bypass, forward, redirect or count) regardless of the other inputs.
- Reset (reset_i=0 at an edge), including mid-operation:
  - regs cleared; wb_valid_o=0, wb_addr_o=0, wb_data_o=0, redirect_o=0, redirect_pc_o=0, retired_o=0.
  - Any redirect pending from the cycle before reset is cancelled.
  - Inputs during reset are ignored.
- Reads during reset are still combinational from the (being-cleared) array.

Test Plan:
1. Reset, then commit ALU r3 = 0x1234_5678 with load_i=0 -> same cycle rd_addr_a_i=3 returns 0x12345678 (bypass); next cycle wb_valid_o=1, wb_addr_o=3, wb_data_o=0x12345678, and a read of r3 returns it from the array; retired_o=1.
2. Load r5 with mem_data_i=0xDEADBEEF and ALU_data_i=0x100 -> r5=0xDEADBEEF; a second write with load_i=0 and ALU_data_i=0x100 then gives r5=0x100.
3. flush_i=1 with valid_i=1, do_write_i=1, r7=0xFFFF -> r7 remains 0, wb_valid_o=0, retired_o unchanged.
4. Commit r15 = 0x0000_2003 -> next cycle redirect_o=1 and redirect_pc_o=0x2000 for one cycle; the shadow slot writing r1=0x55 is dropped (r1 stays 0, count not incremented); a read of r15 returns pc_plus8_i.
5. Store (valid_i=1, do_write_i=0) -> no register write, wb_valid_o=0, retired_o increments; preload the counter to all-ones via force and retire once -> it stays all-ones.
6. Commit r15, then reset_i=0 on the following edge -> redirect_o=0, all registers and retired_o read 0 after reset.

Source files
------------

// File: rtl/wb_stage.sv
// Writeback: picks load/ALU data, writes the register file, and bypasses the committed value to the decode read ports.
// Latency: reads are combinational and forwarding is registered (1 cycle). There is no backpressure, so a slot is accepted every cycle.
module wb_stage #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4,
  parameter int CNT_W  = 32
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic [DATA_W-1:0] ALU_data_i,
  input  logic [DATA_W-1:0] mem_data_i,
  input  logic [ADDR_W-1:0] wb_addr_i,
  input  logic              valid_i,
  input  logic              do_write_i,
  input  logic              load_i,
  input  logic              flush_i,
  input  logic [ADDR_W-1:0] rd_addr_a_i,
  input  logic [ADDR_W-1:0] rd_addr_b_i,
  input  logic [DATA_W-1:0] pc_plus8_i,
  output logic [DATA_W-1:0] rd_data_a_o,
  output logic [DATA_W-1:0] rd_data_b_o,
  output logic              wb_valid_o,
  output logic [ADDR_W-1:0] wb_addr_o,
  output logic [DATA_W-1:0] wb_data_o,
  output logic              redirect_o,
  output logic [DATA_W-1:0] redirect_pc_o,
  output logic [CNT_W-1:0]  retired_o
);

  localparam int NREG = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] PC_IDX = ADDR_W'(NREG - 1);

  // The PC index has no storage; only r0..r(NREG-2) live in the array.
  logic [DATA_W-1:0] regs_q [NREG-1];
  logic [DATA_W-1:0] regs_d [NREG-1];

  logic              wb_valid_q, wb_valid_d;
  logic [ADDR_W-1:0] wb_addr_q, wb_addr_d;
  logic [DATA_W-1:0] wb_data_q, wb_data_d;
  logic              redirect_q, redirect_d;
  logic [DATA_W-1:0] redirect_pc_q, redirect_pc_d;
  logic [CNT_W-1:0]  retired_q, retired_d;

  logic [DATA_W-1:0] wdata;
  logic              commit;
  logic              retire;

  // The slot following a redirect is the shadow of the branch and is squashed.
  always_comb begin
    wdata  = load_i ? mem_data_i : ALU_data_i;
    commit = valid_i & do_write_i & ~flush_i & ~redirect_q;
    retire = valid_i & ~flush_i & ~redirect_q;
  end

  always_comb begin
    regs_d = regs_q;
    if (commit && (wb_addr_i != PC_IDX)) begin
      regs_d[wb_addr_i] = wdata;
    end

    wb_valid_d = commit;
    wb_addr_d  = wb_addr_i;
    wb_data_d  = wdata;

    redirect_d    = commit && (wb_addr_i == PC_IDX);
    redirect_pc_d = redirect_d ? {wdata[DATA_W-1:2], 2'b00} : redirect_pc_q;

    retired_d = retired_q;
    if (retire && (retired_q != {CNT_W{1'b1}})) begin
      retired_d = retired_q + CNT_W'(1);
    end
  end

  always_comb begin
    if (rd_addr_a_i == PC_IDX) begin
      rd_data_a_o = pc_plus8_i;
    end else if (commit && (wb_addr_i == rd_addr_a_i)) begin
      rd_data_a_o = wdata;
    end else begin
      rd_data_a_o = regs_q[rd_addr_a_i];
    end

    if (rd_addr_b_i == PC_IDX) begin
      rd_data_b_o = pc_plus8_i;
    end else if (commit && (wb_addr_i == rd_addr_b_i)) begin
      rd_data_b_o = wdata;
    end else begin
      rd_data_b_o = regs_q[rd_addr_b_i];
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      for (int i = 0; i < NREG - 1; i++) begin
        regs_q[i] <= '0;
      end
      wb_valid_q    <= 1'b0;
      wb_addr_q     <= '0;
      wb_data_q     <= '0;
      redirect_q    <= 1'b0;
      redirect_pc_q <= '0;
      retired_q     <= '0;
    end else begin
      regs_q        <= regs_d;
      wb_valid_q    <= wb_valid_d;
      wb_addr_q     <= wb_addr_d;
      wb_data_q     <= wb_data_d;
      redirect_q    <= redirect_d;
      redirect_pc_q <= redirect_pc_d;
      retired_q     <= retired_d;
    end
  end

  assign wb_valid_o    = wb_valid_q;
  assign wb_addr_o     = wb_addr_q;
  assign wb_data_o     = wb_data_q;
  assign redirect_o    = redirect_q;
  assign redirect_pc_o = redirect_pc_q;
  assign retired_o     = retired_q;

endmodule

// File: tb/tb_wb_stage.sv
// Bench for wb_stage: directed slots, with expected forwards and redirects queued and then checked by a monitor on the falling edge.
module tb_wb_stage;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic [31:0] ALU_data_i, mem_data_i, pc_plus8_i;
  logic [3:0]  wb_addr_i, rd_addr_a_i, rd_addr_b_i;
  logic        valid_i, do_write_i, load_i, flush_i;
  logic [31:0] rd_data_a_o, rd_data_b_o, wb_data_o, redirect_pc_o, retired_o;
  logic [3:0]  wb_addr_o;
  logic        wb_valid_o, redirect_o;

  int total = 0;
  int bad   = 0;

  logic [3:0]  fwd_addr_q[$];
  logic [31:0] fwd_data_q[$];
  logic [31:0] red_pc_q[$];

  wb_stage #(.DATA_W(32), .ADDR_W(4), .CNT_W(32)) dut (
    .clk_i(clk_i), .reset_i(reset_i),
    .ALU_data_i(ALU_data_i), .mem_data_i(mem_data_i), .wb_addr_i(wb_addr_i),
    .valid_i(valid_i), .do_write_i(do_write_i), .load_i(load_i), .flush_i(flush_i),
    .rd_addr_a_i(rd_addr_a_i), .rd_addr_b_i(rd_addr_b_i), .pc_plus8_i(pc_plus8_i),
    .rd_data_a_o(rd_data_a_o), .rd_data_b_o(rd_data_b_o),
    .wb_valid_o(wb_valid_o), .wb_addr_o(wb_addr_o), .wb_data_o(wb_data_o),
    .redirect_o(redirect_o), .redirect_pc_o(redirect_pc_o), .retired_o(retired_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic slot(input logic v, input logic dw, input logic ld, input logic fl,
                      input logic [3:0] wa, input logic [31:0] alu, input logic [31:0] mem);
    valid_i = v; do_write_i = dw; load_i = ld; flush_i = fl;
    wb_addr_i = wa; ALU_data_i = alu; mem_data_i = mem;
  endtask

  task automatic idle();
    slot(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 32'h0, 32'h0);
  endtask

  task automatic exp_fwd(input logic [3:0] a, input logic [31:0] d);
    fwd_addr_q.push_back(a);
    fwd_data_q.push_back(d);
  endtask

  // Monitor: every forward or redirect the DUT presents must match the oldest expectation.
  always @(negedge clk_i) begin
    if (wb_valid_o) begin
      if (fwd_addr_q.size() == 0) begin
        check("fwd_unexpected", {32'h0, 28'h0, wb_addr_o}, 64'hFFFF);
      end else begin
        check("fwd_addr", {60'h0, wb_addr_o}, {60'h0, fwd_addr_q.pop_front()});
        check("fwd_data", {32'h0, wb_data_o}, {32'h0, fwd_data_q.pop_front()});
      end
    end
    if (redirect_o) begin
      if (red_pc_q.size() == 0) begin
        check("redirect_unexpected", {32'h0, redirect_pc_o}, 64'hFFFF_FFFF_FFFF);
      end else begin
        check("redirect_pc", {32'h0, redirect_pc_o}, {32'h0, red_pc_q.pop_front()});
      end
    end
  end

  initial begin
    reset_i = 1'b0;
    idle();
    rd_addr_a_i = 4'd0; rd_addr_b_i = 4'd0;
    pc_plus8_i = 32'h0000_1008;
    repeat (2) tick();
    check("rst_wb_valid", {63'h0, wb_valid_o}, 64'h0);
    check("rst_wb_addr", {60'h0, wb_addr_o}, 64'h0);
    check("rst_wb_data", {32'h0, wb_data_o}, 64'h0);
    check("rst_redirect", {63'h0, redirect_o}, 64'h0);
    check("rst_redirect_pc", {32'h0, redirect_pc_o}, 64'h0);
    check("rst_retired", {32'h0, retired_o}, 64'h0);
    reset_i = 1'b1;

    // 1: ALU write to r3 with bypass on both ports
    slot(1'b1, 1'b1, 1'b0, 1'b0, 4'd3, 32'h1234_5678, 32'hCAFE_0000);
    rd_addr_a_i = 4'd3; rd_addr_b_i = 4'd3;
    exp_fwd(4'd3, 32'h1234_5678);
    #1;
    check("t1_bypass_a", {32'h0, rd_data_a_o}, {32'h0, 32'h1234_5678});
    check("t1_bypass_b", {32'h0, rd_data_b_o}, {32'h0, 32'h1234_5678});
    tick();
    idle();
    #1;
    check("t1_array_r3", {32'h0, rd_data_a_o}, {32'h0, 32'h1234_5678});
    check("t1_retired", {32'h0, retired_o}, 64'd1);

    // 2: load then ALU write to r5
    slot(1'b1, 1'b1, 1'b1, 1'b0, 4'd5, 32'h0000_0100, 32'hDEAD_BEEF);
    exp_fwd(4'd5, 32'hDEAD_BEEF);
    tick();
    idle();
    rd_addr_a_i = 4'd5;
    #1;
    check("t2_load_r5", {32'h0, rd_data_a_o}, {32'h0, 32'hDEAD_BEEF});
    slot(1'b1, 1'b1, 1'b0, 1'b0, 4'd5, 32'h0000_0100, 32'hDEAD_BEEF);
    exp_fwd(4'd5, 32'h0000_0100);
    #1;
    check("t2_bypass_r5", {32'h0, rd_data_a_o}, 64'h100);
    check("t2_other_port_r3", {32'h0, rd_data_b_o}, {32'h0, 32'h1234_5678});
    tick();
    idle();
    #1;
    check("t2_alu_r5", {32'h0, rd_data_a_o}, 64'h100);
    check("t2_retired", {32'h0, retired_o}, 64'd3);

    // 3: flushed write to r7
    slot(1'b1, 1'b1, 1'b0, 1'b1, 4'd7, 32'h0000_FFFF, 32'h0000_FFFF);
    rd_addr_a_i = 4'd7;
    #1;
    check("t3_no_bypass", {32'h0, rd_data_a_o}, 64'h0);
    tick();
    idle();
    #1;
    check("t3_r7", {32'h0, rd_data_a_o}, 64'h0);
    check("t3_wb_valid", {63'h0, wb_valid_o}, 64'h0);
    check("t3_retired", {32'h0, retired_o}, 64'd3);

    // 4: r15 write, shadow slot dropped
    slot(1'b1, 1'b1, 1'b0, 1'b0, 4'd15, 32'h0000_2003, 32'h0);
    rd_addr_a_i = 4'd15;
    exp_fwd(4'd15, 32'h0000_2003);
    red_pc_q.push_back(32'h0000_2000);
    #1;
    check("t4_r15_read_pc", {32'h0, rd_data_a_o}, 64'h1008);
    tick();
    slot(1'b1, 1'b1, 1'b0, 1'b0, 4'd1, 32'h0000_0055, 32'h0);
    rd_addr_a_i = 4'd1;
    #1;
    check("t4_redirect_hi", {63'h0, redirect_o}, 64'h1);
    check("t4_shadow_no_bypass", {32'h0, rd_data_a_o}, 64'h0);
    tick();
    idle();
    pc_plus8_i = 32'h0000_2224;
    rd_addr_b_i = 4'd15;
    #1;
    check("t4_r1", {32'h0, rd_data_a_o}, 64'h0);
    check("t4_retired", {32'h0, retired_o}, 64'd4);
    check("t4_redirect_one_cycle", {63'h0, redirect_o}, 64'h0);
    check("t4_redirect_pc_hold", {32'h0, redirect_pc_o}, 64'h2000);
    check("t4_r15_port_b", {32'h0, rd_data_b_o}, 64'h2224);

    // 5: store retires without writing, then saturation
    slot(1'b1, 1'b0, 1'b0, 1'b0, 4'd9, 32'h0000_0777, 32'h0);
    rd_addr_a_i = 4'd9;
    #1;
    check("t5_store_no_bypass", {32'h0, rd_data_a_o}, 64'h0);
    tick();
    idle();
    #1;
    check("t5_r9", {32'h0, rd_data_a_o}, 64'h0);
    check("t5_retired", {32'h0, retired_o}, 64'd5);
    force dut.retired_q = 32'hFFFF_FFFF;
    tick();
    release dut.retired_q;
    slot(1'b1, 1'b0, 1'b0, 1'b0, 4'd9, 32'h0, 32'h0);
    tick();
    idle();
    #1;
    check("t5_saturate", {32'h0, retired_o}, 64'hFFFF_FFFF);

    // 6: r15 commit, then reset on the following edge with live inputs
    slot(1'b1, 1'b1, 1'b0, 1'b0, 4'd15, 32'h0000_4007, 32'h0);
    exp_fwd(4'd15, 32'h0000_4007);
    red_pc_q.push_back(32'h0000_4004);
    tick();
    reset_i = 1'b0;
    slot(1'b1, 1'b1, 1'b0, 1'b0, 4'd2, 32'h0000_00AA, 32'h0);
    tick();
    check("t6_redirect", {63'h0, redirect_o}, 64'h0);
    check("t6_redirect_pc", {32'h0, redirect_pc_o}, 64'h0);
    check("t6_retired", {32'h0, retired_o}, 64'h0);
    check("t6_wb_valid", {63'h0, wb_valid_o}, 64'h0);
    check("t6_wb_addr", {60'h0, wb_addr_o}, 64'h0);
    check("t6_wb_data", {32'h0, wb_data_o}, 64'h0);
    slot(1'b1, 1'b1, 1'b0, 1'b0, 4'd15, 32'h0000_8000, 32'h0);
    tick();
    reset_i = 1'b1;
    idle();
    for (int i = 0; i < 15; i++) begin
      rd_addr_a_i = 4'(i);
      #1;
      check($sformatf("t6_reg_r%0d", i), {32'h0, rd_data_a_o}, 64'h0);
    end
    rd_addr_a_i = 4'd15;
    #1;
    check("t6_r15_pc", {32'h0, rd_data_a_o}, 64'h2224);
    repeat (3) tick();
    check("end_fwd_queue_empty", 64'(fwd_addr_q.size()), 64'h0);
    check("end_redirect_queue_empty", 64'(red_pc_q.size()), 64'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
